// File: rtl/tetris_grid_renderer.sv
// Tetris playfield renderer.
// Generates VGA raster timing, latches the 22x10 playfield once per frame
// during vertical blanking, and paints the visible rows as a cell grid with
// a two-pixel border ring. All outputs are registered once and mutually aligned.
module tetris_grid_renderer #(
    parameter int          CELL        = 20,
    parameter int          X0          = 220,
    parameter int          Y0          = 40,
    parameter int          HIDDEN_ROWS = 2,
    parameter logic [11:0] BLOCK_RGB   = 12'h0F0,
    parameter logic [11:0] GRID_RGB    = 12'h333,
    parameter logic [11:0] EDGE_RGB    = 12'hFFF,
    parameter int          H_ACTIVE    = 640,
    parameter int          H_FRONT     = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BACK      = 48,
    parameter int          V_ACTIVE    = 480,
    parameter int          V_FRONT     = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BACK      = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [21:0][9:0] display_array,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [9:0]       x,
    output logic [9:0]       y,
    output logic [11:0]      rgb,
    output logic             frame_start
);

    localparam int ROWS  = 22;
    localparam int COLS  = 10;
    localparam int SUB_W = (CELL > 2) ? $clog2(CELL) : 1;

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] SNAP_V   = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_LO    = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_HI    = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_LO    = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_HI    = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] BX_PRE   = 10'(X0 - 1);
    localparam logic [9:0] BX_LO    = 10'(X0);
    localparam logic [9:0] BX_HI    = 10'(X0 + COLS * CELL - 1);
    localparam logic [9:0] BY_PRE   = 10'(Y0 - 1);
    localparam logic [9:0] BY_LO    = 10'(Y0);
    localparam logic [9:0] BY_HI    = 10'(Y0 + (ROWS - HIDDEN_ROWS) * CELL - 1);
    localparam logic [9:0] RX_LO    = 10'(X0 - 2);
    localparam logic [9:0] RX_HI    = 10'(X0 + COLS * CELL + 1);
    localparam logic [9:0] RY_LO    = 10'(Y0 - 2);
    localparam logic [9:0] RY_HI    = 10'(Y0 + (ROWS - HIDDEN_ROWS) * CELL + 1);

    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CELL - 1);
    localparam logic [3:0]       COL_LAST  = 4'(COLS - 1);
    localparam logic [4:0]       ROW_FIRST = 5'(HIDDEN_ROWS);
    localparam logic [4:0]       ROW_LAST  = 5'(ROWS - 1);

    logic [9:0]             h_cnt;
    logic [9:0]             v_cnt;
    logic [SUB_W-1:0]       col_sub;
    logic [3:0]             col_idx;
    logic [SUB_W-1:0]       row_sub;
    logic [4:0]             row_idx;
    logic [21:0][9:0]       snapshot;

    logic                   active_p0;
    logic                   in_board_p0;
    logic                   in_ring_p0;
    logic                   grid_p0;
    logic                   occ_p0;
    logic                   hsync_p0;
    logic                   vsync_p0;
    logic                   fs_p0;
    logic [11:0]            rgb_p0;

    // Colour priority: blanking, board gridline, occupied cell, empty cell, ring, background.
    function automatic logic [11:0] pick_rgb(input logic act, input logic board,
                                             input logic ring, input logic grid,
                                             input logic occ);
        if (!act)  return 12'h000;
        if (board) return grid ? GRID_RGB : (occ ? BLOCK_RGB : 12'h000);
        if (ring)  return EDGE_RGB;
        return 12'h000;
    endfunction

    // Raster counters: h wraps every line, v advances on each h wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Column sub-counter tracks the cell under h_cnt; restarts just before the board edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_sub <= '0;
            col_idx <= '0;
        end else if (h_cnt == BX_PRE) begin
            col_sub <= '0;
            col_idx <= '0;
        end else if (col_sub == SUB_LAST) begin
            col_sub <= '0;
            if (col_idx != COL_LAST) col_idx <= col_idx + 4'd1;
        end else begin
            col_sub <= col_sub + 1'b1;
        end
    end

    // Row sub-counter advances once per line; first visible row is the first non-spawn row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_sub <= '0;
            row_idx <= ROW_FIRST;
        end else if (h_cnt == H_LAST) begin
            if (v_cnt == BY_PRE) begin
                row_sub <= '0;
                row_idx <= ROW_FIRST;
            end else if (row_sub == SUB_LAST) begin
                row_sub <= '0;
                if (row_idx != ROW_LAST) row_idx <= row_idx + 5'd1;
            end else begin
                row_sub <= row_sub + 1'b1;
            end
        end
    end

    // Playfield snapshot taken on the last pixel of the last active line so a frame never tears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snapshot <= '0;
        end else if (h_cnt == H_LAST && v_cnt == SNAP_V) begin
            snapshot <= display_array;
        end
    end

    // Stage p0: decode the current counter position into sync, region and colour.
    always_comb begin
        active_p0   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        in_board_p0 = (h_cnt >= BX_LO) && (h_cnt <= BX_HI) &&
                      (v_cnt >= BY_LO) && (v_cnt <= BY_HI);
        in_ring_p0  = (h_cnt >= RX_LO) && (h_cnt <= RX_HI) &&
                      (v_cnt >= RY_LO) && (v_cnt <= RY_HI) && !in_board_p0;
        grid_p0     = (col_sub == '0) || (row_sub == '0);
        occ_p0      = snapshot[row_idx][col_idx];
        hsync_p0    = !((h_cnt >= HS_LO) && (h_cnt <= HS_HI));
        vsync_p0    = !((v_cnt >= VS_LO) && (v_cnt <= VS_HI));
        fs_p0       = (h_cnt == 10'd0) && (v_cnt == 10'd0);
        rgb_p0      = pick_rgb(active_p0, in_board_p0, in_ring_p0, grid_p0, occ_p0);
    end

    // Stage p1: single output register keeps every output aligned to the same pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hsync_p0;
            vsync       <= vsync_p0;
            de          <= active_p0;
            x           <= active_p0 ? h_cnt : 10'd0;
            y           <= active_p0 ? v_cnt : 10'd0;
            rgb         <= rgb_p0;
            frame_start <= fs_p0;
        end
    end

endmodule

// File: tb/tb_tetris_grid_renderer.sv
// Bench for tetris_grid_renderer on a reduced raster (80x104 total, 64x96 active,
// CELL=4, board at (12,6)) so several whole frames fit in a short run.
// Expected pixels are queued by the stimulus; a negedge monitor matches them
// against the pixel stream and also checks per-frame timing statistics.
module tb_tetris_grid_renderer;

    localparam int CELL = 4, X0 = 12, Y0 = 6, HR = 2;
    localparam int H_ACTIVE = 64, H_FRONT = 4, H_SYNC = 8, H_BACK = 4;
    localparam int V_ACTIVE = 96, V_FRONT = 2, V_SYNC = 2, V_BACK = 4;
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    logic             clk = 1'b0;
    logic             reset;
    logic [21:0][9:0] display_array;
    logic             hsync, vsync, de, frame_start;
    logic [9:0]       x, y;
    logic [11:0]      rgb;

    typedef struct {
        int          fr;
        int          px;
        int          py;
        logic [11:0] rgb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   fr = 0;
    int   pos = 0;
    int   cyc, hs_low, vs_low, de_hi, blank_bad, tim_bad, green;
    int   exp_green [0:7];

    tetris_grid_renderer #(
        .CELL(CELL), .X0(X0), .Y0(Y0), .HIDDEN_ROWS(HR),
        .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) dut (
        .clk(clk), .reset(reset), .display_array(display_array),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .rgb(rgb), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", nm, act, act, req, req);
        end
    endtask

    task automatic push(input int f, input int px, input int py, input logic [11:0] c);
        exp_t e;
        e.fr = f; e.px = px; e.py = py; e.rgb = c;
        sb.push_back(e);
    endtask

    task automatic clear_stats();
        cyc = 0; hs_low = 0; vs_low = 0; de_hi = 0;
        blank_bad = 0; tim_bad = 0; green = 0;
    endtask

    task automatic finish_tb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic wait_frame(input int n);
        for (int i = 0; i < 3 * H_TOTAL * V_TOTAL && fr < n; i++) @(posedge clk);
        if (fr < n) begin
            check($sformatf("timeout_frame%0d", n), fr, n);
            finish_tb();
        end
    endtask

    task automatic wait_line(input int ln);
        int k;
        k = 0;
        while (!(de && int'(y) == ln) && k < 2 * H_TOTAL * V_TOTAL) begin
            @(posedge clk); #1;
            k++;
        end
        if (!(de && int'(y) == ln)) begin
            check($sformatf("timeout_line%0d", ln), int'(y), ln);
            finish_tb();
        end
    endtask

    // Monitor: frame bookkeeping, reference timing model, scoreboard matching.
    always @(negedge clk) begin
        int  lp, ln;
        bit  e_de, e_hs, e_vs;
        if (reset) begin
            fr = 0;
            pos = 0;
            clear_stats();
        end else begin
            if (frame_start) begin
                if (fr >= 1 && fr <= 5) begin
                    check($sformatf("f%0d_cycles", fr), cyc, H_TOTAL * V_TOTAL);
                    check($sformatf("f%0d_hs_low", fr), hs_low, H_SYNC * V_TOTAL);
                    check($sformatf("f%0d_vs_low", fr), vs_low, V_SYNC * H_TOTAL);
                    check($sformatf("f%0d_de_high", fr), de_hi, H_ACTIVE * V_ACTIVE);
                    check($sformatf("f%0d_timing_errs", fr), tim_bad, 0);
                    check($sformatf("f%0d_rgb_in_blank", fr), blank_bad, 0);
                    check($sformatf("f%0d_green_pixels", fr), green, exp_green[fr]);
                end
                fr++;
                pos = 0;
                clear_stats();
            end else begin
                pos++;
            end
            lp   = pos % H_TOTAL;
            ln   = pos / H_TOTAL;
            e_de = (lp < H_ACTIVE) && (ln < V_ACTIVE);
            e_hs = !(lp >= H_ACTIVE + H_FRONT && lp < H_ACTIVE + H_FRONT + H_SYNC);
            e_vs = !(ln >= V_ACTIVE + V_FRONT && ln < V_ACTIVE + V_FRONT + V_SYNC);
            if (hsync != e_hs || vsync != e_vs || de != e_de ||
                int'(x) != (e_de ? lp : 0) || int'(y) != (e_de ? ln : 0))
                tim_bad++;
            cyc++;
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (de) de_hi++;
            if (!de && rgb != 12'h000) blank_bad++;
            if (rgb == 12'h0F0) green++;
            if (de) begin
                for (int i = sb.size() - 1; i >= 0; i--) begin
                    if (sb[i].fr == fr && sb[i].px == int'(x) && sb[i].py == int'(y)) begin
                        check($sformatf("pix_f%0d_(%0d,%0d)", fr, sb[i].px, sb[i].py),
                              int'(rgb), int'(sb[i].rgb));
                        sb.delete(i);
                    end
                end
            end
        end
    end

    // Stimulus: reset behaviour, then a sequence of playfield updates across frames.
    initial begin
        reset = 1'b1;
        display_array = '0;
        for (int i = 0; i < 8; i++) exp_green[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2 reset = 1'b0;

        // Let the raster run into the middle of the first line, then reset asynchronously.
        repeat (100) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_hsync", int'(hsync), 1);
        check("rst_vsync", int'(vsync), 1);
        check("rst_de", int'(de), 0);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_rgb", int'(rgb), 0);
        check("rst_frame_start", int'(frame_start), 0);

        display_array[21][0] = 1'b1;
        @(negedge clk);
        @(negedge clk); #2 reset = 1'b0;
        @(posedge clk); #1;
        check("first_frame_start", int'(frame_start), 1);
        check("first_de", int'(de), 1);
        check("first_x", int'(x), 0);
        check("first_y", int'(y), 0);

        // Frame 1: snapshot still empty; border ring and background.
        push(1, 10, 50, 12'hFFF);
        push(1, 53, 50, 12'hFFF);
        push(1, 30, 4, 12'hFFF);
        push(1, 30, 87, 12'hFFF);
        push(1, 9, 50, 12'h000);
        push(1, 54, 50, 12'h000);
        push(1, 13, 83, 12'h000);
        // Frame 2: bottom-left cell [21][0] occupied (x 12..15, y 82..85).
        push(2, 13, 83, 12'h0F0);
        push(2, 12, 83, 12'h333);
        push(2, 13, 82, 12'h333);
        push(2, 17, 83, 12'h000);
        push(2, 12, 50, 12'h333);
        push(2, 11, 50, 12'hFFF);
        exp_green[1] = 0;
        exp_green[2] = 9;
        exp_green[3] = 0;
        exp_green[4] = 0;
        exp_green[5] = 9;

        // During frame 2: only spawn-row bits set; they must never be drawn.
        wait_frame(2);
        display_array = '0;
        display_array[0][5] = 1'b1;
        display_array[1][5] = 1'b1;
        push(3, 13, 83, 12'h000);
        push(3, 33, 7, 12'h000);

        // Mid frame 4: set cell [10][3] (x 24..27, y 38..41); visible only from frame 5.
        wait_frame(4);
        wait_line(20);
        display_array[10][3] = 1'b1;
        push(4, 25, 39, 12'h000);
        push(5, 25, 39, 12'h0F0);
        push(5, 24, 39, 12'h333);

        wait_frame(6);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_unmatched actual=%0d required=0", sb.size());
        end
        finish_tb();
    end

endmodule
